// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio transmitter and its clock generator.
package audio_pkg;
  localparam int unsigned ACCUM_INC_DEF   = 245760;
  localparam int unsigned ACCUM_MOD_DEF   = 742500;
  localparam int unsigned SLOTS_PER_FRAME = 64;
  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned SLOT_W          = $clog2(SLOTS_PER_FRAME);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } sample_pair_t;

  // Data bits start one slot after each word-select change (I2S one-bit delay).
  function automatic logic in_data_slot(input logic [SLOT_W-1:0] slot, input logic is_right);
    int unsigned lo;
    int unsigned s;
    lo = is_right ? (SLOTS_PER_FRAME / 2) + 32'd1 : 32'd1;
    s  = 32'(slot);
    return (s >= lo) && (s < lo + SAMPLE_W);
  endfunction
endpackage

// File: rtl/audio_clk_gen.sv
// Fractional-accumulator MCLK generator with a /4 SCLK divider; strobes the
// clk cycle in which SCLK falls so the serializer can update its outputs.
module audio_clk_gen
  import audio_pkg::*;
#(
  parameter int unsigned ACCUM_INC = ACCUM_INC_DEF,
  parameter int unsigned ACCUM_MOD = ACCUM_MOD_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic audio_mclk,
  output logic shift_evt
);
  localparam int unsigned ACCUM_W = $clog2(ACCUM_MOD + ACCUM_INC);
  localparam logic [ACCUM_W-1:0] INC = ACCUM_W'(ACCUM_INC);
  localparam logic [ACCUM_W-1:0] MOD = ACCUM_W'(ACCUM_MOD);

  logic [ACCUM_W-1:0] accum;
  logic [1:0]         div;
  logic               wrap;
  logic               mclk_rise;

  assign wrap      = (accum >= MOD);
  assign mclk_rise = wrap && !audio_mclk;
  // Divider wrapping 3->0 is the SCLK (div[1]) falling edge.
  assign shift_evt = mclk_rise && (div == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum      <= '0;
      div        <= 2'd0;
      audio_mclk <= 1'b0;
    end else begin
      if (wrap) begin
        accum      <= accum - MOD + INC;
        audio_mclk <= ~audio_mclk;
      end else begin
        accum <= accum + INC;
      end
      if (mclk_rise) div <= div + 2'd1;
    end
  end
endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: a one-deep sample holding register feeding a 64-slot
// frame serializer, timed by the fractional MCLK/SCLK generator.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned ACCUM_INC = ACCUM_INC_DEF,
  parameter int unsigned ACCUM_MOD = ACCUM_MOD_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_dac,
  output logic                underrun
);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);

  logic              shift_evt;
  logic              frame_start;
  logic              hold_full;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  sample_pair_t      hold;
  sample_pair_t      shifter;

  audio_clk_gen #(
    .ACCUM_INC(ACCUM_INC),
    .ACCUM_MOD(ACCUM_MOD)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .audio_mclk(audio_mclk),
    .shift_evt (shift_evt)
  );

  assign sample_ready = ~hold_full;
  assign slot_nxt     = slot + SLOT_W'(1);
  assign frame_start  = shift_evt && (slot == LAST_SLOT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot       <= LAST_SLOT;
      hold_full  <= 1'b0;
      hold       <= '0;
      shifter    <= '0;
      audio_lrck <= 1'b0;
      audio_dac  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (sample_valid && !hold_full) begin
        hold      <= '{l: sample_l, r: sample_r};
        hold_full <= 1'b1;
      end
      if (shift_evt) begin
        slot       <= slot_nxt;
        audio_lrck <= slot_nxt[SLOT_W-1];
        audio_dac  <= 1'b0;
        if (frame_start) begin
          // An empty holding register at frame start sends a silent frame.
          if (hold_full) begin
            shifter   <= hold;
            hold_full <= 1'b0;
          end else begin
            shifter  <= '0;
            underrun <= 1'b1;
          end
        end else if (in_data_slot(slot_nxt, 1'b0)) begin
          audio_dac <= shifter.l[SAMPLE_W-1];
          shifter.l <= shifter.l << 1;
        end else if (in_data_slot(slot_nxt, 1'b1)) begin
          audio_dac <= shifter.r[SAMPLE_W-1];
          shifter.r <= shifter.r << 1;
        end
      end
    end
  end
endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter ACCUM_INC, default 245760: fractional MCLK accumulator increment.
REQ-002 SHALL have parameter ACCUM_MOD, default 742500: accumulator modulus, so a 74.25 MHz clk yields a 12.288 MHz MCLK.
REQ-003 SHALL have port clk, input, 1 bit: single clock (clk_74a domain); one clock, no other clock used internally.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sample_l, input, 16 bits: left PCM, signed two's complement.
REQ-006 SHALL have port sample_r, input, 16 bits: right PCM, signed two's complement.
REQ-007 SHALL have port sample_valid, input, 1 bit: sample pair offered.
REQ-008 SHALL have port sample_ready, output, 1 bit: holding register empty.
REQ-009 SHALL have port audio_mclk, output, 1 bit: master clock, registered.
REQ-010 SHALL have port audio_lrck, output, 1 bit: word select; 0 = left.
REQ-011 SHALL have port audio_dac, output, 1 bit: serial data.
REQ-012 SHALL have port underrun, output, 1 bit: one-clk pulse.

Function
REQ-013 SHALL add ACCUM_INC to the accumulator every clk; when accum >= ACCUM_MOD, SHALL toggle audio_mclk and load accum - ACCUM_MOD + ACCUM_INC.
REQ-014 SHALL advance a 2-bit divider on each MCLK rising toggle (0->1); SCLK = divider[1], 3.072 MHz.
REQ-015 SHALL define the shift event as the clk cycle in which the divider wraps 3->0 (SCLK falling edge); all lrck/dac updates occur only on shift events.
REQ-016 SHALL keep a 6-bit slot counter (0..63), incremented on each shift event, wrapping 63->0.
REQ-017 SHALL drive audio_lrck = 0 for slots 0..31 and 1 for slots 32..63, giving 48 kHz frames.
REQ-018 SHALL drive audio_dac = left[16-s] for slots s=1..16 and right[48-s] for slots s=33..48, MSB first with I2S one-bit delay; SHALL drive 0 in all other slots.
REQ-019 SHALL treat sample_ready = NOT hold_full, combinational from a register.
REQ-020 SHALL capture {sample_l, sample_r} into the holding register and set hold_full on a clk where sample_valid && sample_ready.
REQ-021 On the shift event entering slot 0 (frame start), if hold_full: SHALL copy the holding register to the output shift pair and clear hold_full.
REQ-022 On the shift event entering slot 0, if not hold_full: SHALL load zero into the shift pair and pulse underrun high for exactly that clk.
REQ-023 If the frame latch and sample_valid coincide while full: no capture occurs, since ready=0 that cycle; ready rises the next clk.
REQ-024 SHALL deliver a sample accepted at any point before a frame start in that frame; latency from accept to first MSB on audio_dac is at most one frame plus one slot.
REQ-025 SHALL make the outputs glitch-free: audio_mclk, audio_lrck, audio_dac and underrun are direct flop outputs.

Reset
REQ-026 On reset_n low: accum=0, divider=0, slot=63 (so the first shift event enters slot 0), hold_full=0, shift pair=0.
REQ-027 On reset_n low: audio_mclk=0, audio_lrck=0, audio_dac=0, underrun=0; sample_ready=1.
REQ-028 Reset asserted mid-frame SHALL discard the held and in-flight samples immediately; there is no partial-frame resume.

Structure
REQ-029 SHALL place ACCUM_INC/ACCUM_MOD defaults, SLOTS_PER_FRAME=64 and SAMPLE_W=16 as constants in shared package audio_pkg.
REQ-030 SHALL isolate the MCLK accumulator plus SCLK divider in sub-module audio_clk_gen, which outputs audio_mclk and a shift-event strobe; serializer and handshake stay in audio_i2s_tx.

Verification
REQ-031 Bench SHALL check: free-run 1 ms after reset -> 12288±1 MCLK rising edges, 48 lrck periods, 64 SCLK falling events per frame.
REQ-032 Bench SHALL check: offer L=16'hA5C3, R=16'h8001 before frame start -> slots 1..16 serialize 1010010111000011, slots 33..48 serialize 1000000000000001, other slots 0.
REQ-033 Bench SHALL check: no sample offered for 3 frames -> dac stays 0 and exactly 3 underrun pulses, each 1 clk wide, coincident with the slot-0 events.
REQ-034 Bench SHALL check: hold sample_valid high continuously with incrementing data -> one sample accepted per frame, no drops, no underrun, and ready low between accept and next frame start.
REQ-035 Bench SHALL check: valid asserted on the exact frame-start clk while hold_full -> the old pair is transmitted, the new pair is accepted the following clk, and the new pair is transmitted the next frame.
REQ-036 Bench SHALL check: reset_n pulsed low during slot 40 -> all outputs 0 asynchronously, ready=1, and the first post-reset frame carries zeros with an underrun pulse.
